vga_compositor: RTL and testbench
=================================

Name: vga_compositor

Overview:
Pixel-output stage directly downstream of the 640x480 timing generator and the rectangle animators. Each pixel strobe, it tests the current (x, y) against N_OBJ rectangles, selects the highest-priority colour, and blanks outside the active area. It re-times sync so that colour and sync arrive at the pins aligned, and it latches per-frame overlap flags between object 0 and every other object for game logic.

Parameters:
N_OBJ, 3, number of rectangle layers; index 0 has highest priority.
H_ACTIVE, 640, visible pixels per line.
V_ACTIVE, 480, visible lines per frame.
BG_RGB, 8'h00, background colour {R[1:0],G[2:0],B[2:0]}.

Ports:
i_clk  in  1  system clock (100 MHz).
i_rst  in  1  asynchronous, active-low reset.
i_pix_stb  in  1  pixel-enable strobe; the pipeline advances only when it is high.
i_hs  in  1  horizontal sync from the timing generator.
i_vs  in  1  vertical sync from the timing generator.
i_x  in  10  current pixel column.
i_y  in  9  current pixel row.
i_frame_end  in  1  one-strobe pulse at the end of the active frame (animate).
i_obj_en  in  N_OBJ  per-layer enable.
i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2  in  12*N_OBJ each  packed rectangle bounds; layer k occupies bits [12k+11:12k].
i_obj_rgb  in  8*N_OBJ  packed layer colours {R2,G3,B3}.
o_hs  out  1  delayed horizontal sync.
o_vs  out  1  delayed vertical sync.
o_r  out  2  red.
o_g  out  3  green.
o_b  out  3  blue.
o_collide  out  N_OBJ  bit k: layer 0 overlapped layer k during the last frame; bit 0 is always 0.

Behaviour:
- Reset (asynchronous, i_rst low): all pipeline registers cleared, o_hs = o_vs = 1 (inactive, since sync is active-low), o_r/o_g/o_b = 0, o_collide = 0, collision accumulator = 0.
- All registers update only on i_clk edges where i_pix_stb = 1; otherwise they hold.
- Stage 1 (hit):
  - x and y are zero-extended to 12 bits.
  - hit[k] = en[k] & (x > x1[k]) & (x < x2[k]) & (y > y1[k]) & (y < y2[k]). Comparisons are strict and unsigned.
  - active = (x < H_ACTIVE) & (y < V_ACTIVE).
  - hit, active, hs and vs are registered.
- Stage 2 (select):
  - When active is 0, rgb = 0.
  - Otherwise rgb = colour of the lowest index k with hit[k] set, or BG_RGB if no layer hits.
  - rgb, hs and vs are registered onto the output pins.
- Latency: exactly 2 strobes from (i_x, i_y, i_hs, i_vs) to (o_rgb, o_hs, o_vs). Sync and colour stay mutually aligned.
- Collision:
  - Accumulator acc[k] |= stage-1 active & hit[0] & hit[k] on each strobe, for k ≥ 1.
  - On a strobe with i_frame_end = 1: o_collide <= acc | (current strobe's contribution), then acc <= 0.
  - The same-strobe contribution is included in o_collide and is not carried into the next frame.
  - o_collide holds its value until the next i_frame_end strobe.
- Object inputs may change on any strobe (animators update at frame end). The block samples them combinationally in stage 1, so no additional hazard handling is needed.
- If i_frame_end arrives without i_pix_stb, it is ignored.
- Reset mid-frame: outputs are blanked immediately. The first valid pixel appears 2 strobes after release.
- Degenerate rectangles (x2 ≤ x1 + 1 or y2 ≤ y1 + 1) never hit.

Decomposition:
- Shared package vga_pkg holds:
  - RGB_W = 8 and the R/G/B field slices;
  - H_ACTIVE_640 / V_ACTIVE_480 constants;
  - COORD_W = 12.
- One natural sub-module: rect_hit. It is a purely combinational 12-bit bounds test, instantiated N_OBJ times via a generate loop. Pipeline, priority mux and collision logic stay in vga_compositor.

Test Plan:
- Reset: hold i_rst = 0 with random inputs -> o_hs = o_vs = 1, RGB = 0, o_collide = 0. Release, drive x = 10, y = 10, no layers enabled -> RGB = BG_RGB on the 2nd strobe, not the 1st.
- Bounds: layer 0 at x1 = 100, x2 = 110, y1 = 50, y2 = 60, colour 8'hE0, y = 55, sweep x -> colour only for x = 101..109. x = 100 and x = 110 give the background.
- Priority: layers 0 (8'hE0) and 1 (8'h1C) both cover (200, 200) -> 8'hE0. Disable layer 0 -> 8'h1C.
- Blanking/alignment: x = 650, y = 100 inside a layer rectangle -> RGB = 0. A toggle of i_hs appears on o_hs exactly 2 strobes later, together with the colour of the same pixel.
- Stall: hold i_pix_stb = 0 for 5 clocks mid-line -> all outputs frozen. Resume -> sequence continues with no skipped or duplicated pixel.
- Collision: layers 0 and 2 overlap at a single pixel in frame N -> after i_frame_end, o_collide = 3'b100. Frame N+1 with no overlap -> o_collide = 3'b000 after the next i_frame_end. Overlap only on the i_frame_end strobe itself -> bit set for that frame only.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-output path.
// Holds the colour word layout ({R[1:0],G[2:0],B[2:0]}), the coordinate width
// used by the rectangle comparators, and the 640x480 visible-area limits.
package vga_pkg;

   localparam int RGB_W   = 8;
   localparam int COORD_W = 12;

   // Colour field positions inside the packed 8-bit RGB word.
   localparam int R_HI = 7;
   localparam int R_LO = 6;
   localparam int G_HI = 5;
   localparam int G_LO = 3;
   localparam int B_HI = 2;
   localparam int B_LO = 0;

   localparam int H_ACTIVE_640 = 640;
   localparam int V_ACTIVE_480 = 480;

   typedef logic [RGB_W-1:0]   rgb_t;
   typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/rect_hit.sv
// Combinational rectangle membership test.
// Ports:
//   i_en             layer enable
//   i_x, i_y         pixel coordinate (already widened to COORD_W)
//   i_x1, i_x2       horizontal bounds (exclusive)
//   i_y1, i_y2       vertical bounds (exclusive)
//   o_hit            pixel lies strictly inside the rectangle and layer is enabled
// Strict comparisons mean a rectangle with x2 <= x1+1 or y2 <= y1+1 never hits.
module rect_hit
   import vga_pkg::*;
(
   input  logic   i_en,
   input  coord_t i_x,
   input  coord_t i_y,
   input  coord_t i_x1,
   input  coord_t i_x2,
   input  coord_t i_y1,
   input  coord_t i_y2,
   output logic   o_hit
);

   assign o_hit = i_en & (i_x > i_x1) & (i_x < i_x2) & (i_y > i_y1) & (i_y < i_y2);

endmodule

// File: rtl/vga_compositor.sv
// Pixel-output stage between the timing generator / rectangle animators and
// the VGA pins. Two-strobe pipeline: stage 1 tests the pixel against every
// layer rectangle, stage 2 picks the highest-priority colour (layer 0 wins)
// or blanks outside the visible area. Sync is delayed by the same two strobes
// so it stays aligned with colour. Overlaps between layer 0 and each other
// layer are accumulated over a frame and published on i_frame_end.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_pix_stb             pipeline advance enable
//   i_hs, i_vs            sync in (active-low)
//   i_x, i_y              current pixel
//   i_frame_end           end-of-frame pulse, qualified by i_pix_stb
//   i_obj_*               packed per-layer enables, bounds and colours
//   o_hs, o_vs            delayed sync
//   o_r, o_g, o_b         pixel colour
//   o_collide             per-layer overlap with layer 0 over the last frame
module vga_compositor
   import vga_pkg::*;
#(
   parameter int         N_OBJ    = 3,
   parameter int         H_ACTIVE = H_ACTIVE_640,
   parameter int         V_ACTIVE = V_ACTIVE_480,
   parameter logic [7:0] BG_RGB   = 8'h00
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_pix_stb,
   input  logic                     i_hs,
   input  logic                     i_vs,
   input  logic [9:0]               i_x,
   input  logic [8:0]               i_y,
   input  logic                     i_frame_end,
   input  logic [N_OBJ-1:0]         i_obj_en,
   input  logic [COORD_W*N_OBJ-1:0] i_obj_x1,
   input  logic [COORD_W*N_OBJ-1:0] i_obj_x2,
   input  logic [COORD_W*N_OBJ-1:0] i_obj_y1,
   input  logic [COORD_W*N_OBJ-1:0] i_obj_y2,
   input  logic [RGB_W*N_OBJ-1:0]   i_obj_rgb,
   output logic                     o_hs,
   output logic                     o_vs,
   output logic [1:0]               o_r,
   output logic [2:0]               o_g,
   output logic [2:0]               o_b,
   output logic [N_OBJ-1:0]         o_collide
);

   localparam coord_t H_LIM = COORD_W'(H_ACTIVE);
   localparam coord_t V_LIM = COORD_W'(V_ACTIVE);

   coord_t           x_ext, y_ext;
   logic [N_OBJ-1:0] hit_d, hit_q;
   logic             active_d, active_q;
   logic             hs_q, vs_q;
   rgb_t             rgb_d, rgb_q;
   logic             hs_out_q, vs_out_q;
   logic [N_OBJ-1:0] contrib, acc_d, acc_q, collide_d, collide_q;

   // ---- Stage 1: bounds test ----
   assign x_ext    = COORD_W'(i_x);
   assign y_ext    = COORD_W'(i_y);
   assign active_d = (x_ext < H_LIM) & (y_ext < V_LIM);

   for (genvar k = 0; k < N_OBJ; k++) begin : g_hit
      rect_hit u_rect_hit (
         .i_en  (i_obj_en[k]),
         .i_x   (x_ext),
         .i_y   (y_ext),
         .i_x1  (i_obj_x1[COORD_W*k +: COORD_W]),
         .i_x2  (i_obj_x2[COORD_W*k +: COORD_W]),
         .i_y1  (i_obj_y1[COORD_W*k +: COORD_W]),
         .i_y2  (i_obj_y2[COORD_W*k +: COORD_W]),
         .o_hit (hit_d[k])
      );
   end

   // ---- Stage 2: priority select and blanking ----
   always_comb begin
      rgb_d = BG_RGB;
      // Walk from lowest priority up so the lowest hitting index wins.
      for (int k = N_OBJ - 1; k >= 0; k--) begin
         if (hit_q[k]) rgb_d = i_obj_rgb[RGB_W*k +: RGB_W];
      end
      if (!active_q) rgb_d = '0;
   end

   // Collision uses the stage-1 result of the current strobe so the pixel
   // presented together with i_frame_end still counts toward the closing frame.
   always_comb begin
      contrib = '0;
      for (int k = 1; k < N_OBJ; k++) begin
         contrib[k] = active_d & hit_d[0] & hit_d[k];
      end
      acc_d     = acc_q | contrib;
      collide_d = collide_q;
      if (i_frame_end) begin
         collide_d = acc_q | contrib;
         acc_d     = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         hit_q     <= '0;
         active_q  <= 1'b0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         rgb_q     <= '0;
         hs_out_q  <= 1'b1;
         vs_out_q  <= 1'b1;
         acc_q     <= '0;
         collide_q <= '0;
      end else if (i_pix_stb) begin
         hit_q     <= hit_d;
         active_q  <= active_d;
         hs_q      <= i_hs;
         vs_q      <= i_vs;
         rgb_q     <= rgb_d;
         hs_out_q  <= hs_q;
         vs_out_q  <= vs_q;
         acc_q     <= acc_d;
         collide_q <= collide_d;
      end
   end

   assign o_hs      = hs_out_q;
   assign o_vs      = vs_out_q;
   assign o_r       = rgb_q[R_HI:R_LO];
   assign o_g       = rgb_q[G_HI:G_LO];
   assign o_b       = rgb_q[B_HI:B_LO];
   assign o_collide = collide_q;

endmodule

// File: tb/tb_vga_compositor.sv
// Directed bench for vga_compositor.
module tb_vga_compositor;

   localparam int         N_OBJ = 3;
   localparam logic [7:0] BG    = 8'h25;

   logic                i_clk = 1'b0;
   logic                i_rst = 1'b0;
   logic                i_pix_stb = 1'b0;
   logic                i_hs = 1'b1;
   logic                i_vs = 1'b1;
   logic [9:0]          i_x = '0;
   logic [8:0]          i_y = '0;
   logic                i_frame_end = 1'b0;
   logic [N_OBJ-1:0]    i_obj_en = '0;
   logic [12*N_OBJ-1:0] i_obj_x1 = '0, i_obj_x2 = '0, i_obj_y1 = '0, i_obj_y2 = '0;
   logic [8*N_OBJ-1:0]  i_obj_rgb = '0;
   logic                o_hs, o_vs;
   logic [1:0]          o_r;
   logic [2:0]          o_g, o_b;
   logic [N_OBJ-1:0]    o_collide;
   logic [7:0]          rgb;

   int checks = 0;
   int errors = 0;

   assign rgb = {o_r, o_g, o_b};

   vga_compositor #(.N_OBJ(N_OBJ), .BG_RGB(BG)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
      .i_hs(i_hs), .i_vs(i_vs), .i_x(i_x), .i_y(i_y),
      .i_frame_end(i_frame_end), .i_obj_en(i_obj_en),
      .i_obj_x1(i_obj_x1), .i_obj_x2(i_obj_x2),
      .i_obj_y1(i_obj_y1), .i_obj_y2(i_obj_y2), .i_obj_rgb(i_obj_rgb),
      .o_hs(o_hs), .o_vs(o_vs), .o_r(o_r), .o_g(o_g), .o_b(o_b),
      .o_collide(o_collide)
   );

   always #5 i_clk = ~i_clk;

   task automatic set_obj(input int k, input int x1, input int x2,
                          input int y1, input int y2, input logic [7:0] c);
      i_obj_x1[12*k +: 12] = 12'(x1);
      i_obj_x2[12*k +: 12] = 12'(x2);
      i_obj_y1[12*k +: 12] = 12'(y1);
      i_obj_y2[12*k +: 12] = 12'(y2);
      i_obj_rgb[8*k +: 8]  = c;
   endtask

   // One pixel strobe; outputs are sampled 1 time unit after the edge.
   task automatic pix(input int x, input int y, input logic hs, input logic fe);
      i_pix_stb   = 1'b1;
      i_x         = 10'(x);
      i_y         = 9'(y);
      i_hs        = hs;
      i_frame_end = fe;
      @(posedge i_clk);
      #1;
      i_frame_end = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         i_pix_stb = 1'b1;
         i_hs = 1'($urandom); i_vs = 1'($urandom);
         i_x = 10'($urandom_range(0, 639)); i_y = 9'($urandom_range(0, 479));
         i_frame_end = 1'($urandom);
         i_obj_en = 3'($urandom);
         i_obj_x1 = {$urandom, 4'h0}; i_obj_x2 = {$urandom, 4'hF};
         i_obj_y1 = {$urandom, 4'h0}; i_obj_y2 = {$urandom, 4'hF};
         i_obj_rgb = 24'($urandom);
         @(posedge i_clk);
         #1;
      end
      checks++; if (o_hs !== 1'b1) begin errors++; $display("FAIL reset_hs got %b want 1", o_hs); end
      checks++; if (o_vs !== 1'b1) begin errors++; $display("FAIL reset_vs got %b want 1", o_vs); end
      checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb got %h want 00", rgb); end
      checks++; if (o_collide !== 3'b000) begin errors++; $display("FAIL reset_collide got %b want 000", o_collide); end
      i_obj_en = '0;
      i_vs = 1'b1;
      i_frame_end = 1'b0;
      i_rst = 1'b1;
      pix(10, 10, 1'b1, 1'b0);
      checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL reset_first_strobe got %h want 00", rgb); end
      pix(10, 10, 1'b1, 1'b0);
      checks++; if (rgb !== BG) begin errors++; $display("FAIL reset_second_strobe got %h want %h", rgb, BG); end
   endtask

   task automatic test_bounds();
      logic [7:0] exp_c;
      int xx;
      set_obj(0, 100, 110, 50, 60, 8'hE0);
      i_obj_en = 3'b001;
      for (int i = 0; i < 16; i++) begin
         pix(98 + i, 55, 1'b1, 1'b0);
         if (i >= 1) begin
            xx = 98 + i - 1;
            exp_c = (xx >= 101 && xx <= 109) ? 8'hE0 : BG;
            checks++;
            if (rgb !== exp_c) begin
               errors++; $display("FAIL bounds_x%0d got %h want %h", xx, rgb, exp_c);
            end
         end
      end
      // Degenerate rectangle (x2 = x1 + 1) on layer 1 never hits.
      set_obj(1, 200, 201, 50, 60, 8'h1C);
      i_obj_en = 3'b010;
      pix(200, 55, 1'b1, 1'b0);
      pix(201, 55, 1'b1, 1'b0);
      checks++; if (rgb !== BG) begin errors++; $display("FAIL degenerate_x200 got %h want %h", rgb, BG); end
      pix(201, 55, 1'b1, 1'b0);
      checks++; if (rgb !== BG) begin errors++; $display("FAIL degenerate_x201 got %h want %h", rgb, BG); end
   endtask

   task automatic test_priority();
      set_obj(0, 150, 250, 150, 250, 8'hE0);
      set_obj(1, 190, 210, 190, 210, 8'h1C);
      i_obj_en = 3'b011;
      pix(200, 200, 1'b1, 1'b0);
      pix(200, 200, 1'b1, 1'b0);
      checks++; if (rgb !== 8'hE0) begin errors++; $display("FAIL priority_both got %h want e0", rgb); end
      i_obj_en = 3'b010;
      pix(200, 200, 1'b1, 1'b0);
      pix(200, 200, 1'b1, 1'b0);
      checks++; if (rgb !== 8'h1C) begin errors++; $display("FAIL priority_l1_only got %h want 1c", rgb); end
   endtask

   task automatic test_blank_align();
      int         vx [6] = '{650, 630, 650, 630, 630, 650};
      logic       vh [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] ve [6] = '{8'h00, 8'h03, 8'h00, 8'h03, 8'h03, 8'h00};
      set_obj(2, 600, 700, 50, 150, 8'h03);
      i_obj_en = 3'b100;
      for (int i = 0; i < 7; i++) begin
         pix((i < 6) ? vx[i] : 630, 100, (i < 6) ? vh[i] : 1'b1, 1'b0);
         if (i >= 1) begin
            checks++;
            if (o_hs !== vh[i-1] || rgb !== ve[i-1]) begin
               errors++;
               $display("FAIL align_%0d got hs=%b rgb=%h want hs=%b rgb=%h", i - 1, o_hs, rgb, vh[i-1], ve[i-1]);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [7:0] exp_c;
      set_obj(2, 302, 306, 10, 30, 8'h03);
      i_obj_en = 3'b100;
      for (int x = 300; x <= 303; x++) pix(x, 20, x[0], 1'b0);
      // Pipeline now shows pixel 302 (background, hs = 0); freeze it.
      for (int c = 0; c < 5; c++) begin
         i_pix_stb = 1'b0;
         i_x = 10'd500; i_hs = ~i_hs; i_frame_end = 1'b1;
         @(posedge i_clk);
         #1;
         checks++;
         if (rgb !== BG || o_hs !== 1'b0) begin
            errors++; $display("FAIL stall_cycle%0d got hs=%b rgb=%h want hs=0 rgb=%h", c, o_hs, rgb, BG);
         end
      end
      i_frame_end = 1'b0;
      for (int x = 304; x <= 308; x++) begin
         pix(x, 20, x[0], 1'b0);
         exp_c = ((x - 1) >= 303 && (x - 1) <= 305) ? 8'h03 : BG;
         checks++;
         if (rgb !== exp_c || o_hs !== 1'((x - 1) & 1)) begin
            errors++;
            $display("FAIL stall_resume_x%0d got hs=%b rgb=%h want hs=%0d rgb=%h", x - 1, o_hs, rgb, (x - 1) & 1, exp_c);
         end
      end
   endtask

   task automatic test_collision();
      // Layer 0/1 overlapped at (200,200) during the priority test; the
      // frame_end pulses during the stall were unqualified and ignored.
      set_obj(0, 100, 110, 50, 60, 8'hE0);
      set_obj(2, 108, 120, 40, 56, 8'h03);
      i_obj_en = 3'b101;
      pix(5, 5, 1'b1, 1'b1);
      checks++; if (o_collide !== 3'b010) begin errors++; $display("FAIL collide_prior got %b want 010", o_collide); end
      // Frame N: single overlapping pixel (109,52).
      pix(50, 52, 1'b1, 1'b0);
      pix(109, 52, 1'b1, 1'b0);
      pix(5, 5, 1'b1, 1'b0);
      checks++; if (o_collide !== 3'b010) begin errors++; $display("FAIL collide_hold got %b want 010", o_collide); end
      pix(5, 5, 1'b1, 1'b1);
      checks++; if (o_collide !== 3'b100) begin errors++; $display("FAIL collide_frameN got %b want 100", o_collide); end
      // Frame N+1: no overlap.
      pix(108, 52, 1'b1, 1'b0);
      pix(5, 5, 1'b1, 1'b1);
      checks++; if (o_collide !== 3'b000) begin errors++; $display("FAIL collide_frameN1 got %b want 000", o_collide); end
      // Overlap only on the frame_end strobe itself.
      pix(5, 5, 1'b1, 1'b0);
      pix(109, 55, 1'b1, 1'b1);
      checks++; if (o_collide !== 3'b100) begin errors++; $display("FAIL collide_same_strobe got %b want 100", o_collide); end
      pix(5, 5, 1'b1, 1'b1);
      checks++; if (o_collide !== 3'b000) begin errors++; $display("FAIL collide_not_carried got %b want 000", o_collide); end
      // Overlap, then frame_end without a strobe (ignored), then a real one.
      pix(109, 51, 1'b1, 1'b0);
      i_pix_stb = 1'b0; i_frame_end = 1'b1; i_x = 10'd5; i_y = 9'd5;
      @(posedge i_clk);
      #1;
      i_frame_end = 1'b0;
      checks++; if (o_collide !== 3'b000) begin errors++; $display("FAIL collide_fe_no_stb got %b want 000", o_collide); end
      pix(5, 5, 1'b1, 1'b1);
      checks++; if (o_collide !== 3'b100) begin errors++; $display("FAIL collide_after_ignored got %b want 100", o_collide); end
   endtask

   task automatic test_reset_midframe();
      set_obj(0, 100, 110, 50, 60, 8'hE0);
      i_obj_en = 3'b001;
      pix(105, 55, 1'b0, 1'b0);
      pix(105, 55, 1'b0, 1'b0);
      #2;
      i_rst = 1'b0;
      #1;
      checks++;
      if (rgb !== 8'h00 || o_hs !== 1'b1 || o_collide !== 3'b000) begin
         errors++; $display("FAIL midframe_reset got rgb=%h hs=%b col=%b want rgb=00 hs=1 col=000", rgb, o_hs, o_collide);
      end
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      pix(105, 55, 1'b1, 1'b0);
      checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL midframe_first got %h want 00", rgb); end
      pix(105, 55, 1'b1, 1'b0);
      checks++; if (rgb !== 8'hE0) begin errors++; $display("FAIL midframe_second got %h want e0", rgb); end
   endtask

   initial begin
      test_reset();
      test_bounds();
      test_priority();
      test_blank_align();
      test_stall();
      test_collision();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
